bsg_counter_set_down: RTL

Loadable down-counter: the consumer-side counterpart of the clear/up counter. Software or a credit source loads a start value, downstream events decrement it, and the block reports when the count reaches zero. Typical uses are timeout timers, burst-length trackers and credit return counters that drain what an up-counter accumulated. Count saturates at zero and never wraps.

---
 rtl/bsg_counter_set_down_if.sv | 25 ++
 rtl/bsg_counter_set_down.sv | 55 +++++
 2 files changed

// File: rtl/bsg_counter_set_down_if.sv
// Load/decrement strobes and count/status outputs of bsg_counter_set_down.
// The master drives the strobes and the slave (the counter) drives the status.
interface bsg_counter_set_down_if #(
  parameter int unsigned width_p = 24
) ();

  logic               set_i;
  logic [width_p-1:0] val_i;
  logic               down_i;
  logic [width_p-1:0] count_o;
  logic               zero_o;
  logic               done_o;
  logic               underflow_o;

  modport master (
    output set_i, val_i, down_i,
    input  count_o, zero_o, done_o, underflow_o
  );

  modport slave (
    input  set_i, val_i, down_i,
    output count_o, zero_o, done_o, underflow_o
  );

endinterface

// File: rtl/bsg_counter_set_down.sv
// Loadable down-counter that saturates at zero. It gives a done pulse on a
// 1 -> 0 decrement and a sticky underflow flag for a decrement issued at zero.
module bsg_counter_set_down #(
  parameter int unsigned max_val_p  = 10000000,
  parameter int unsigned width_p    = $clog2(max_val_p + 1),
  parameter int unsigned init_val_p = 0
) (
  input logic                   clk_i,
  input logic                   reset_n_i,
  bsg_counter_set_down_if.slave bus
);

  localparam logic [width_p-1:0] max_lp  = width_p'(max_val_p);
  localparam logic [width_p-1:0] init_lp = width_p'(init_val_p);

  logic [width_p-1:0] count_r, count_n;
  logic               done_r, done_n;
  logic               underflow_r, underflow_n;

  // Next state: a load wins over a decrement, and a decrement at zero only flags underflow.
  always_comb begin
    count_n     = count_r;
    done_n      = 1'b0;
    underflow_n = underflow_r;
    if (bus.set_i) begin
      count_n     = (bus.val_i > max_lp) ? max_lp : bus.val_i;
      underflow_n = 1'b0;
    end else if (bus.down_i) begin
      if (count_r != '0) begin
        count_n = count_r - width_p'(1);
        done_n  = (count_r == width_p'(1));
      end else begin
        underflow_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count_r     <= init_lp;
      done_r      <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      count_r     <= count_n;
      done_r      <= done_n;
      underflow_r <= underflow_n;
    end
  end

  assign bus.count_o     = count_r;
  assign bus.zero_o      = (count_r == '0);
  assign bus.done_o      = done_r;
  assign bus.underflow_o = underflow_r;

endmodule
